// File: rtl/viterbi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : viterbi_pkg                                                  |
// | Description : Shared helpers for the parametrised Viterbi decoder: ceil    |
// |               log2, soft branch distance, encoder parity, trellis          |
// |               predecessor lookup and initial path-metric value.            |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package viterbi_pkg;

   // Ceiling log2, never below 1 so it can size a counter directly.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return (result < 1) ? 1 : result;
   endfunction

   // Soft distance of received value x from code bit c.
   // 0 is a confident '0' and 2**soft_w-1 is a confident '1'.
   function automatic int soft_dist(input int x, input logic c, input int soft_w);
      return c ? (((1 << soft_w) - 1) - x) : x;
   endfunction

   // Encoder output bit for register contents r and generator g.
   function automatic logic parity(input int r, input int g);
      return ^(r & g);
   endfunction

   // Predecessor of state n whose oldest bit is b (states are K-1 bits wide).
   function automatic int pred(input int n, input logic b, input int k);
      return ((n << 1) | int'(b)) & ((1 << (k - 1)) - 1);
   endfunction

   // Initial path metric for every state other than 0.
   function automatic int pm_init(input int pm_w);
      return 1 << (pm_w - 2);
   endfunction

endpackage : viterbi_pkg
`default_nettype wire

// File: rtl/viterbi_acs_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : viterbi_acs_unit                                             |
// | Description : Add-compare-select for one trellis state. Adds the branch    |
// |               metric to each predecessor metric, keeps the smaller (ties   |
// |               go to predecessor a) and extends the winning survivor.       |
// | Ports       : pm_a/pm_b     predecessor path metrics                       |
// |               bm_a/bm_b     branch metrics into this state                 |
// |               surv_a/surv_b predecessor survivors                          |
// |               dec_bit       input bit implied by entering this state       |
// |               pm_out        selected path metric                           |
// |               surv_out      selected survivor with dec_bit appended        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module viterbi_acs_unit #(
   parameter int PM_W     = 10,
   parameter int BM_W     = 4,
   parameter int TB_DEPTH = 15
) (
   input  logic [PM_W-1:0]     pm_a,
   input  logic [BM_W-1:0]     bm_a,
   input  logic [PM_W-1:0]     pm_b,
   input  logic [BM_W-1:0]     bm_b,
   input  logic [TB_DEPTH-1:0] surv_a,
   input  logic [TB_DEPTH-1:0] surv_b,
   input  logic                dec_bit,
   output logic [PM_W-1:0]     pm_out,
   output logic [TB_DEPTH-1:0] surv_out
);

   logic [PM_W-1:0] w_sum_a;
   logic [PM_W-1:0] w_sum_b;
   logic            w_take_b;

   // Metric width leaves headroom above the normalisation point, so no wrap.
   assign w_sum_a  = pm_a + PM_W'(bm_a);
   assign w_sum_b  = pm_b + PM_W'(bm_b);
   assign w_take_b = (w_sum_b < w_sum_a);

   assign pm_out   = w_take_b ? w_sum_b : w_sum_a;
   // Oldest bit drops off the top; newest decision enters at bit 0.
   assign surv_out = {(w_take_b ? surv_b[TB_DEPTH-2:0] : surv_a[TB_DEPTH-2:0]), dec_bit};

endmodule : viterbi_acs_unit
`default_nettype wire

// File: rtl/viterbi_core_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : viterbi_core_param                                           |
// | Description : Soft-decision rate-1/2 Viterbi decoder with register-        |
// |               exchange survivors, metric normalisation and sync clear.     |
// | Ports       : clk, rst_n (async, active low), clear (sync re-init)         |
// |               sym_valid, sym0, sym1   soft code-bit pair input             |
// |               out_valid               one-cycle decoded-bit strobe         |
// |               out_bit                 decoded bit, TB_DEPTH-1 symbols late |
// |               best_metric             winning path metric                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module viterbi_core_param
   import viterbi_pkg::*;
#(
   parameter int           K        = 3,
   parameter logic [K-1:0] G0       = 3'b111,
   parameter logic [K-1:0] G1       = 3'b101,
   parameter int           SOFT_W   = 3,
   parameter int           TB_DEPTH = 15,
   parameter int           PM_W     = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              sym_valid,
   input  logic [SOFT_W-1:0] sym0,
   input  logic [SOFT_W-1:0] sym1,
   output logic              out_valid,
   output logic              out_bit,
   output logic [PM_W-1:0]   best_metric
);

   localparam int                  c_NS       = 1 << (K - 1);
   localparam int                  c_SW       = K - 1;
   localparam int                  c_BM_W     = SOFT_W + 1;
   localparam int                  c_FILL_W   = clog2(TB_DEPTH);
   localparam logic [PM_W-1:0]     c_PM_INIT  = PM_W'(pm_init(PM_W));
   localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(TB_DEPTH - 1);

   logic [PM_W-1:0]     r_pm       [c_NS];
   logic [TB_DEPTH-1:0] r_surv     [c_NS];
   logic [c_FILL_W-1:0] r_fill;

   logic [c_BM_W-1:0]   w_bm       [4];
   logic [PM_W-1:0]     w_pm_acs   [c_NS];
   logic [PM_W-1:0]     w_pm_new   [c_NS];
   logic [TB_DEPTH-1:0] w_surv_new [c_NS];
   logic                w_all_high;
   logic [PM_W-1:0]     w_tree_val [2*c_NS-1];
   logic [c_SW-1:0]     w_tree_idx [2*c_NS-1];
   logic [c_SW-1:0]     w_best;
   logic                w_emit;

   // Only four distinct code pairs exist, so compute each branch metric once
   // and let every state pick its pair by index {c0,c1}.
   for (genvar cc = 0; cc < 4; cc++) begin : g_bm
      localparam logic [1:0] c_CODE = 2'(cc);
      assign w_bm[cc] = c_BM_W'(soft_dist(int'(sym0), c_CODE[1], SOFT_W)
                              + soft_dist(int'(sym1), c_CODE[0], SOFT_W));
   end

   for (genvar n = 0; n < c_NS; n++) begin : g_state
      localparam int         c_PA     = pred(n, 1'b0, K);
      localparam int         c_PB     = pred(n, 1'b1, K);
      localparam logic       c_U      = 1'((n >> (K - 2)) & 1);
      // Encoder register contents {u, predecessor state} for each branch.
      localparam int         c_REG_A  = (int'(c_U) << (K - 1)) | c_PA;
      localparam int         c_REG_B  = (int'(c_U) << (K - 1)) | c_PB;
      localparam logic [1:0] c_CODE_A = {parity(c_REG_A, int'(G0)), parity(c_REG_A, int'(G1))};
      localparam logic [1:0] c_CODE_B = {parity(c_REG_B, int'(G0)), parity(c_REG_B, int'(G1))};

      viterbi_acs_unit #(
         .PM_W     (PM_W),
         .BM_W     (c_BM_W),
         .TB_DEPTH (TB_DEPTH)
      ) u_acs (
         .pm_a     (r_pm[c_PA]),
         .bm_a     (w_bm[c_CODE_A]),
         .pm_b     (r_pm[c_PB]),
         .bm_b     (w_bm[c_CODE_B]),
         .surv_a   (r_surv[c_PA]),
         .surv_b   (r_surv[c_PB]),
         .dec_bit  (c_U),
         .pm_out   (w_pm_acs[n]),
         .surv_out (w_surv_new[n])
      );
   end

   // Once every metric has crossed the half-range point, drop that bit from
   // all of them together; relative ordering is unchanged.
   always_comb begin
      w_all_high = 1'b1;
      for (int i = 0; i < c_NS; i++) begin
         w_all_high = w_all_high & w_pm_acs[i][PM_W-1];
      end
      for (int i = 0; i < c_NS; i++) begin
         w_pm_new[i] = w_pm_acs[i];
         if (w_all_high) w_pm_new[i][PM_W-1] = 1'b0;
      end
   end

   // Binary min tree: leaves at NS-1.., node j has children 2j+1 / 2j+2.
   // Left subtree always holds lower state indices, so '<=' gives the
   // lowest index on a tie.
   always_comb begin
      for (int i = 0; i < 2*c_NS-1; i++) begin
         w_tree_val[i] = '0;
         w_tree_idx[i] = '0;
      end
      for (int i = 0; i < c_NS; i++) begin
         w_tree_val[c_NS-1+i] = w_pm_new[i];
         w_tree_idx[c_NS-1+i] = c_SW'(i);
      end
      for (int j = c_NS - 2; j >= 0; j--) begin
         if (w_tree_val[2*j+1] <= w_tree_val[2*j+2]) begin
            w_tree_val[j] = w_tree_val[2*j+1];
            w_tree_idx[j] = w_tree_idx[2*j+1];
         end else begin
            w_tree_val[j] = w_tree_val[2*j+2];
            w_tree_idx[j] = w_tree_idx[2*j+2];
         end
      end
   end

   assign w_best = w_tree_idx[0];
   // The survivor window is full from the TB_DEPTH-th accepted symbol on.
   assign w_emit = (r_fill == c_FILL_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < c_NS; i++) begin
            r_pm[i]   <= (i == 0) ? '0 : c_PM_INIT;
            r_surv[i] <= '0;
         end
         r_fill      <= '0;
         out_valid   <= 1'b0;
         out_bit     <= 1'b0;
         best_metric <= '0;
      end else if (clear) begin
         for (int i = 0; i < c_NS; i++) begin
            r_pm[i]   <= (i == 0) ? '0 : c_PM_INIT;
            r_surv[i] <= '0;
         end
         r_fill      <= '0;
         out_valid   <= 1'b0;
         out_bit     <= 1'b0;
         best_metric <= '0;
      end else if (sym_valid) begin
         for (int i = 0; i < c_NS; i++) begin
            r_pm[i]   <= w_pm_new[i];
            r_surv[i] <= w_surv_new[i];
         end
         if (!w_emit) r_fill <= r_fill + 1'b1;
         out_valid <= w_emit;
         if (w_emit) begin
            out_bit     <= w_surv_new[w_best][TB_DEPTH-1];
            best_metric <= w_pm_new[w_best];
         end
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule : viterbi_core_param
`default_nettype wire
